// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end sharing one signed pipelined multiplier among NUM_REQ
// requesters. At most one operation is issued per cycle. Each product is routed back to the
// requester that issued it, together with that request's tag.
//
// Ports:
//   clk        clock, all logic on posedge
//   reset      synchronous active-low reset
//   hold       1 = grant nothing this cycle (in-flight ops still complete)
//   req_valid  per-requester request valid
//   req_ready  one-hot grant; an op is accepted when valid & ready
//   req_a/b    per-requester operands, slice i belongs to requester i
//   req_tag    per-requester tag, returned unchanged with the result
//   resp_valid one-hot response strobe (one cycle per op)
//   resp_data  low DATA_LEN bits of the signed product (held when no response)
//   resp_tag   tag of the returning op (held when no response)
//   inflight   ops accepted but not yet returned
//   idle       inflight == 0 and no request pending
//
// multiplier: signed multiplier, low DATA_LEN product bits, PIPELINE_STAGE register stages.
// Ports: i_clk, i_rst (sync active-high), i_a, i_b, o_p.

module multiplier #(
   parameter int unsigned DATA_LEN       = 32,
   parameter int unsigned PIPELINE_STAGE = 2
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [DATA_LEN-1:0] i_a,
   input  logic [DATA_LEN-1:0] i_b,
   output logic [DATA_LEN-1:0] o_p
);

   // Low half of a two's-complement product is identical for signed and unsigned operands.
   logic [DATA_LEN-1:0] w_p;
   logic [DATA_LEN-1:0] r_pipe [PIPELINE_STAGE];

   assign w_p = i_a * i_b;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < PIPELINE_STAGE; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= w_p;
         for (int i = 1; i < PIPELINE_STAGE; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_p = r_pipe[PIPELINE_STAGE-1];

endmodule

module mult_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DATA_LEN       = 32,
   parameter int unsigned PIPELINE_STAGE = 2,
   parameter int unsigned TAG_LEN        = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                hold,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ*DATA_LEN-1:0]         req_a,
   input  logic [NUM_REQ*DATA_LEN-1:0]         req_b,
   input  logic [NUM_REQ*TAG_LEN-1:0]          req_tag,
   output logic [NUM_REQ-1:0]                  resp_valid,
   output logic [DATA_LEN-1:0]                 resp_data,
   output logic [TAG_LEN-1:0]                  resp_tag,
   output logic [$clog2(PIPELINE_STAGE+3)-1:0] inflight,
   output logic                                idle
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned INF_W = $clog2(PIPELINE_STAGE + 3);
   localparam int unsigned TRK_N = PIPELINE_STAGE + 1;

   logic [PTR_W-1:0]    r_ptr;
   logic [NUM_REQ-1:0]  w_grant;
   logic [PTR_W-1:0]    w_gnt_idx;
   logic [PTR_W-1:0]    w_idx;
   logic                w_accept;
   logic [DATA_LEN-1:0] w_a;
   logic [DATA_LEN-1:0] w_b;
   logic [TAG_LEN-1:0]  w_tag;
   logic [DATA_LEN-1:0] w_prod;
   logic                w_dec;

   logic [DATA_LEN-1:0] r_iss_a;
   logic [DATA_LEN-1:0] r_iss_b;

   // Tracking entry 0 is loaded on the same edge as the issue register, so its valid bit
   // doubles as the issue valid. Entry TRK_N-1 lines up with the multiplier output.
   logic                r_trk_v   [TRK_N];
   logic [PTR_W-1:0]    r_trk_id  [TRK_N];
   logic [TAG_LEN-1:0]  r_trk_tag [TRK_N];

   logic [NUM_REQ-1:0]  r_resp_valid;
   logic [DATA_LEN-1:0] r_resp_data;
   logic [TAG_LEN-1:0]  r_resp_tag;
   logic [INF_W-1:0]    r_inflight;

   // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      w_grant   = '0;
      w_gnt_idx = '0;
      w_idx     = '0;
      w_accept  = 1'b0;
      if (reset && !hold) begin
         for (int unsigned off = 0; off < NUM_REQ; off++) begin
            w_idx = PTR_W'((32'(r_ptr) + off) % NUM_REQ);
            if (!w_accept && req_valid[w_idx]) begin
               w_accept         = 1'b1;
               w_grant[w_idx]   = 1'b1;
               w_gnt_idx        = w_idx;
            end
         end
      end
   end

   assign req_ready = w_grant;
   assign w_a       = req_a[32'(w_gnt_idx)*DATA_LEN +: DATA_LEN];
   assign w_b       = req_b[32'(w_gnt_idx)*DATA_LEN +: DATA_LEN];
   assign w_tag     = req_tag[32'(w_gnt_idx)*TAG_LEN +: TAG_LEN];
   assign w_dec     = |r_resp_valid;

   multiplier #(
      .DATA_LEN       (DATA_LEN),
      .PIPELINE_STAGE (PIPELINE_STAGE)
   ) u_mult (
      .i_clk (clk),
      .i_rst (~reset),
      .i_a   (r_iss_a),
      .i_b   (r_iss_b),
      .o_p   (w_prod)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ptr        <= '0;
         r_iss_a      <= '0;
         r_iss_b      <= '0;
         r_resp_valid <= '0;
         r_resp_data  <= '0;
         r_resp_tag   <= '0;
         r_inflight   <= '0;
         for (int i = 0; i < TRK_N; i++) begin
            r_trk_v[i]   <= 1'b0;
            r_trk_id[i]  <= '0;
            r_trk_tag[i] <= '0;
         end
      end else begin
         if (w_accept) begin
            r_ptr   <= (32'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + PTR_W'(1);
            r_iss_a <= w_a;
            r_iss_b <= w_b;
         end

         // Shifts every cycle; idle cycles enter as bubbles.
         r_trk_v[0]   <= w_accept;
         r_trk_id[0]  <= w_gnt_idx;
         r_trk_tag[0] <= w_tag;
         for (int i = 1; i < TRK_N; i++) begin
            r_trk_v[i]   <= r_trk_v[i-1];
            r_trk_id[i]  <= r_trk_id[i-1];
            r_trk_tag[i] <= r_trk_tag[i-1];
         end

         if (r_trk_v[TRK_N-1]) begin
            r_resp_valid <= NUM_REQ'(1) << r_trk_id[TRK_N-1];
            r_resp_data  <= w_prod;
            r_resp_tag   <= r_trk_tag[TRK_N-1];
         end else begin
            r_resp_valid <= '0;
         end

         unique case ({w_accept, w_dec})
            2'b10:   r_inflight <= r_inflight + INF_W'(1);
            2'b01:   r_inflight <= r_inflight - INF_W'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   assign resp_valid = r_resp_valid;
   assign resp_data  = r_resp_data;
   assign resp_tag   = r_resp_tag;
   assign inflight   = r_inflight;
   assign idle       = (r_inflight == '0) && !(|req_valid);

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter at default parameters (4 requesters, 32-bit, 2 stages).
module tb_mult_arbiter;

   logic         clk;
   logic         reset;
   logic         hold;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic [15:0]  req_tag;
   logic [3:0]   resp_valid;
   logic [31:0]  resp_data;
   logic [3:0]   resp_tag;
   logic [2:0]   inflight;
   logic         idle;

   typedef struct {
      int          id;
      logic [31:0] data;
      logic [3:0]  tag;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   exp_t        n;
   logic [31:0] exp_prod [4];
   logic [31:0] bb_exp [8];
   int          cyc;
   int          total;
   int          bad;

   mult_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .hold       (hold),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_tag    (req_tag),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_tag   (resp_tag),
      .inflight   (inflight),
      .idle       (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t, input logic [31:0] p);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
      req_tag[i*4 +: 4] = t;
      exp_prod[i]       = p;
   endtask

   // Monitor: pushes an expectation for every accept, pops and checks every response.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               n.id   = i;
               n.data = exp_prod[i];
               n.tag  = req_tag[i*4 +: 4];
               n.cyc  = cyc + 4;
               q.push_back(n);
            end
         end
         if (resp_valid != 4'b0) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_resp: got resp_valid=%b expected none (cycle %0d)",
                        resp_valid, cyc);
            end else begin
               e = q.pop_front();
               chk("resp_valid", 32'(resp_valid), 32'(1) << e.id);
               chk("resp_data", resp_data, e.data);
               chk("resp_tag", 32'(resp_tag), 32'(e.tag));
               chk("resp_cycle", cyc, e.cyc);
            end
         end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            total++;
            bad++;
            $display("FAIL missing_resp: got none expected id=%0d by cycle %0d (cycle %0d)",
                     q[0].id, q[0].cyc, cyc);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      total     = 0;
      bad       = 0;
      reset     = 1'b0;
      hold      = 1'b0;
      req_valid = 4'hF;
      req_a     = '0;
      req_b     = '0;
      req_tag   = '0;
      for (int i = 0; i < 4; i++) exp_prod[i] = '0;
      bb_exp = '{32'd0, 32'd3, 32'd6, 32'd9, 32'd12, 32'd15, 32'd18, 32'd21};

      // Reset state
      tick();
      tick();
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_resp_data", resp_data, 32'h0);
      chk("rst_resp_tag", 32'(resp_tag), 32'h0);
      chk("rst_inflight", 32'(inflight), 32'h0);
      tick();
      reset     = 1'b1;
      req_valid = 4'h0;
      @(negedge clk);
      chk("idle_after_rst", 32'(idle), 32'h1);

      // Single op on requester 2: 7 * -3 = -21
      tick();
      set_op(2, 32'd7, 32'hFFFF_FFFD, 4'd5, 32'hFFFF_FFEB);
      req_valid = 4'b0100;
      @(negedge clk);
      chk("single_ready", 32'(req_ready), 32'h4);
      chk("single_idle_busy", 32'(idle), 32'h0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         req_valid = 4'b0000;
         @(negedge clk);
         chk("single_inflight", 32'(inflight), (k <= 4) ? 32'h1 : 32'h0);
      end
      chk("single_idle_done", 32'(idle), 32'h1);

      // Overflow cases; pointer is 3, so requester 0 wins by wrapping
      tick();
      set_op(0, 32'h7FFF_FFFF, 32'd2, 4'hA, 32'hFFFF_FFFE);
      req_valid = 4'b0001;
      @(negedge clk);
      chk("ovf0_ready", 32'(req_ready), 32'h1);
      tick();
      set_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hB, 32'h8000_0000);
      req_valid = 4'b0010;
      @(negedge clk);
      chk("ovf1_ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = 4'b0000;
      repeat (6) tick();

      // Requester 3 alone brings the pointer back to 0: -4 * -5 = 20
      set_op(3, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 4'hC, 32'd20);
      req_valid = 4'b1000;
      @(negedge clk);
      chk("align_ready", 32'(req_ready), 32'h8);
      tick();
      req_valid = 4'b0000;
      repeat (6) tick();

      // All four valid for 8 cycles
      set_op(0, 32'd1, 32'd10, 4'd0, 32'd10);
      set_op(1, 32'd2, 32'd10, 4'd0, 32'd20);
      set_op(2, 32'd3, 32'd10, 4'd0, 32'd30);
      set_op(3, 32'd4, 32'd10, 4'd0, 32'd40);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) tick();
         req_valid = 4'hF;
         for (int i = 0; i < 4; i++) req_tag[i*4 +: 4] = 4'(k);
         @(negedge clk);
         chk("rr_ready", 32'(req_ready), 32'(1) << (k % 4));
         chk("rr_inflight", 32'(inflight), (k < 4) ? 32'(k) : 32'd4);
      end
      tick();
      req_valid = 4'b0000;
      repeat (6) tick();

      // Two ops in flight, then hold for 3 cycles with requesters 1 and 3 pending
      set_op(3, 32'd3, 32'd5, 4'd1, 32'd15);
      req_valid = 4'b1000;
      @(negedge clk);
      chk("hold_pre3_ready", 32'(req_ready), 32'h8);
      tick();
      set_op(0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 4'd2, 32'd4);
      req_valid = 4'b0001;
      @(negedge clk);
      chk("hold_pre0_ready", 32'(req_ready), 32'h1);
      tick();
      hold      = 1'b1;
      req_valid = 4'b1010;
      set_op(1, 32'd100, 32'hFFFF_FFFF, 4'd3, 32'hFFFF_FF9C);
      req_tag[12 +: 4] = 4'd4;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) tick();
         @(negedge clk);
         chk("hold_ready", 32'(req_ready), 32'h0);
         chk("hold_inflight", 32'(inflight), 32'd2);
      end
      tick();
      hold = 1'b0;
      @(negedge clk);
      chk("hold_rel1_ready", 32'(req_ready), 32'h2);
      tick();
      @(negedge clk);
      chk("hold_rel3_ready", 32'(req_ready), 32'h8);
      tick();
      req_valid = 4'b0000;
      repeat (6) tick();

      // Reset two cycles after accepting two ops
      set_op(0, 32'd6, 32'd7, 4'd6, 32'd42);
      set_op(1, 32'hFFFF_FFF8, 32'd9, 4'd7, 32'hFFFF_FFB8);
      req_valid = 4'b0011;
      @(negedge clk);
      chk("rst_mid0_ready", 32'(req_ready), 32'h1);
      tick();
      @(negedge clk);
      chk("rst_mid1_ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = 4'b0000;
      tick();
      reset = 1'b0;
      q.delete();
      tick();
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         @(negedge clk);
         chk("post_rst_inflight", 32'(inflight), 32'h0);
         chk("post_rst_idle", 32'(idle), 32'h1);
      end
      tick();
      set_op(1, 32'd100, 32'hFFFF_FFFF, 4'd9, 32'hFFFF_FF9C);
      req_valid = 4'b1010;
      @(negedge clk);
      chk("post_rst_grant", 32'(req_ready), 32'h2);
      tick();
      req_valid = 4'b0000;
      repeat (6) tick();

      // Back-to-back on requester 0 only
      for (int k = 0; k < 8; k++) begin
         if (k > 0) tick();
         set_op(0, 32'(k), 32'd3, 4'(k), bb_exp[k]);
         req_valid = 4'b0001;
         @(negedge clk);
         chk("b2b_ready", 32'(req_ready), 32'h1);
      end
      tick();
      req_valid = 4'b0000;
      repeat (8) tick();
      @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
